input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Conditions raw push-button/switch inputs before they reach the combinational gate modules (and/or/xor lab gates) on the board.
- Per bit, it does three things:
  - synchronises the asynchronous pin with 2 flops;
  - filters contact bounce with a stability counter;
  - emits a clean level plus single-cycle rise/fall pulses.
- Sits directly upstream of the gate logic: dout[1:0] drives gate inputs a, b.

Parameters:
- WIDTH, 2, number of independent input bits debounced.
- STABLE_CYCLES, 50000, consecutive cycles a changed synchronised value must persist before dout follows (1 ms at 50 MHz); legal range >= 2.
- CNT_W, 16, stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  raw asynchronous pin inputs.
- dout  output  WIDTH  debounced level, registered.
- rise  output  WIDTH  1-cycle pulse when dout[i] goes 0->1.
- fall  output  WIDTH  1-cycle pulse when dout[i] goes 1->0.

Behaviour:
- Interface fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a clk edge): sync flops=0, counters=0, every bit's FSM=STABLE, dout=0, rise=0, fall=0. Reset mid-count discards the pending change.
- Synchroniser: s1<=din, s2<=s1. s2 is the only value the filter sees, giving 2 cycles of sync latency.
- Per-bit FSM, states STABLE and PENDING:
  - STABLE: if s2!=dout, go to PENDING with cnt<=1; else stay with cnt<=0.
  - PENDING, s2==dout (bounce back): go to STABLE, cnt<=0, dout unchanged, no pulse.
  - PENDING, s2!=dout and cnt==STABLE_CYCLES-1: dout<=~dout, go to STABLE, cnt<=0.
  - PENDING, otherwise: cnt<=cnt+1.
- Net effect: dout toggles on the edge after s2 has differed from dout for STABLE_CYCLES consecutive sampled cycles.
- Latency: a clean din edge appears on dout STABLE_CYCLES+2 cycles later. A glitch shorter than STABLE_CYCLES cycles (at s2) never reaches dout.
- rise[i]/fall[i] are registered and asserted in the same cycle that dout[i] first shows the new value, for exactly 1 cycle. Both are never high together for one bit.
- Bits are fully independent. Simultaneous changes on several bits each obey their own counter.
- Counter width: cnt never exceeds STABLE_CYCLES-1, so no wrap. Elaboration fails (generate-time error) if STABLE_CYCLES<2 or 2^CNT_W<=STABLE_CYCLES.

Optional Feature:
- Macro DEBOUNCE_ACTIVE_LOW_EN.
- Defined: s1 samples ~din, for active-low buttons with pull-ups. Pressed (pin=0) yields dout=1. Reset values are unchanged (dout=0 = released).
- Undefined: s1 samples din directly (active-high inputs).
- Both builds otherwise cycle-identical.

Decomposition:
- Shared package/include holds:
  - FSM state encoding (ST_STABLE=1'b0, ST_PENDING=1'b1);
  - default STABLE_CYCLES constants for the 50 MHz board (DB_CYCLES_1MS) and for simulation (DB_CYCLES_SIM=4).
- One sub-module, debounce_bit: single-bit synchroniser + FSM + counter + pulse regs.
- input_debouncer generate-instantiates WIDTH copies of debounce_bit.

Test Plan (STABLE_CYCLES=4, WIDTH=2):
- Reset: hold rst=1 3 cycles with din=2'b11 -> dout=00, rise=fall=00 throughout. Release rst -> dout[1:0]=11 exactly 6 cycles after the first non-reset edge, with rise=11 for 1 cycle.
- Clean edge: din[0] 0->1 held -> dout[0]=1 on edge 6 after change, rise[0]=1 only that cycle, fall=00, dout[1] unaffected.
- Bounce rejection: din[0] pattern 1,0,1,0,1 each 2 cycles, then held 1 -> dout[0] rises once, 6 cycles after the final 0->1 transition; no pulses earlier.
- Glitch: din[1]=1 for 3 cycles then 0 -> dout[1] stays 0, rise[1] never asserted.
- Reset mid-count: din[0] 0->1, assert rst 3 cycles later for 1 cycle -> dout[0]=0 and no rise during/after reset until a full 6-cycle re-qualification completes.
- DEBOUNCE_ACTIVE_LOW_EN build: din=2'b10 held -> dout=2'b01 after 6 cycles, rise=01 for 1 cycle.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// ============================================================================
// Module   : input_debouncer_pkg
// Purpose  : Shared FSM encoding, board/simulation debounce constants and a
//            configuration sanity helper for the input debouncer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package input_debouncer_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_e;

  // 1 ms at the 50 MHz board clock, and a short value for simulation.
  localparam int DB_CYCLES_1MS = 50000;
  localparam int DB_CYCLES_SIM = 4;

  // True when the counter can hold STABLE_CYCLES-1 and the filter is meaningful.
  function automatic bit db_cfg_ok(input int cycles, input int cnt_w);
    longint unsigned cap;
    if (cycles < 2 || cnt_w < 1) return 1'b0;
    if (cnt_w >= 63) return 1'b1;
    cap = 64'd1 << cnt_w;
    return cap > longint'(cycles);
  endfunction

endpackage

`default_nettype wire

// File: rtl/input_debouncer_debounce_bit.sv
// ============================================================================
// Module   : debounce_bit
// Purpose  : Single-bit 2-flop synchroniser, stability-counter debounce FSM
//            and registered rise/fall pulses.
//            Macro DEBOUNCE_ACTIVE_LOW_EN: invert the pin (pressed = pin low).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_bit
  import input_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DB_CYCLES_1MS,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_dout,
  output logic o_rise,
  output logic o_fall
);

  if (!db_cfg_ok(STABLE_CYCLES, CNT_W)) begin : g_bad_cfg
    $error("debounce_bit: need STABLE_CYCLES >= 2 and 2**CNT_W > STABLE_CYCLES");
  end

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic             w_pin;
  logic             r_s1;
  logic             r_s2;
  logic             r_dout;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;
  db_state_e        r_state;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
  assign w_pin = ~i_din;
`else
  assign w_pin = i_din;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
      r_state <= ST_STABLE;
    end else begin
      r_s1   <= w_pin;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          if (r_s2 != r_dout) begin
            r_state <= ST_PENDING;
            r_cnt   <= c_cnt_one;
          end else begin
            r_cnt   <= '0;
          end
        end
        ST_PENDING: begin
          if (r_s2 == r_dout) begin
            // Bounced back before qualifying: drop the pending change.
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_cnt_last) begin
            r_dout  <= ~r_dout;
            r_rise  <= ~r_dout;
            r_fall  <= r_dout;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + c_cnt_one;
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_dout = r_dout;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/input_debouncer.sv
// ============================================================================
// Module   : input_debouncer
// Purpose  : WIDTH independent push-button/switch debouncers feeding the
//            lab gate inputs. Macro DEBOUNCE_ACTIVE_LOW_EN selects
//            active-low pins (handled inside debounce_bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = DB_CYCLES_1MS,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .i_din  (din[gi]),
      .o_dout (dout[gi]),
      .o_rise (rise[gi]),
      .o_fall (fall[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// ============================================================================
// Module   : tb_input_debouncer
// Purpose  : Directed, table-driven check of input_debouncer (WIDTH=2,
//            STABLE_CYCLES=4). Honours DEBOUNCE_ACTIVE_LOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debouncer;
  import input_debouncer_pkg::*;

  localparam int W  = 2;
  localparam int SC = DB_CYCLES_SIM;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         rst;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  vec_t vecs[40];
  int   nv = 0;

  input_debouncer #(
    .WIDTH         (W),
    .STABLE_CYCLES (SC),
    .CNT_W         (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  // Logical (pressed = 1) value to physical pin level.
  function automatic logic [W-1:0] pin(input logic [W-1:0] v);
`ifdef DEBOUNCE_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic push(input logic r, input logic [W-1:0] d, input logic [W-1:0] o,
                      input logic [W-1:0] ri, input logic [W-1:0] fa, input int n = 1);
    for (int k = 0; k < n; k++) begin
      vecs[nv] = '{rst: r, din: d, dout: o, rise: ri, fall: fa};
      nv++;
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step_raw(input logic r, input logic [W-1:0] d);
    rst = r;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic [W-1:0] d);
    step_raw(r, pin(d));
  endtask

  task automatic expect3(input string name, input logic [W-1:0] o,
                         input logic [W-1:0] ri, input logic [W-1:0] fa);
    chk({name, ".dout"}, dout, o);
    chk({name, ".rise"}, rise, ri);
    chk({name, ".fall"}, fall, fa);
  endtask

  // n cycles with constant input, output level held and no pulses.
  task automatic hold(input string name, input logic [W-1:0] d, input logic [W-1:0] o, input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, d);
      expect3(name, o, 2'b00, 2'b00);
    end
  endtask

  initial begin
    // Reset with both buttons pressed, then both qualify together.
    push(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 3);
    push(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 5);
    push(1'b0, 2'b11, 2'b11, 2'b11, 2'b00);
    push(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2);
    // Clean release of bit 0, bit 1 untouched.
    push(1'b0, 2'b10, 2'b11, 2'b00, 2'b00, 5);
    push(1'b0, 2'b10, 2'b10, 2'b00, 2'b01);
    push(1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 2);
    // Clean press of bit 0.
    push(1'b0, 2'b11, 2'b10, 2'b00, 2'b00, 5);
    push(1'b0, 2'b11, 2'b11, 2'b01, 2'b00);
    push(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2);

    for (int i = 0; i < nv; i++) begin
      step(vecs[i].rst, vecs[i].din);
      expect3($sformatf("vec%0d", i), vecs[i].dout, vecs[i].rise, vecs[i].fall);
    end

    // Bounce on bit 0: 1,0,1,0 for 2 cycles each, then held 1.
    repeat (8) step(1'b0, 2'b10);
    chk("bounce.pre", dout, 2'b10);
    for (int s = 0; s < 4; s++)
      hold("bounce.seg", (s % 2 == 0) ? 2'b11 : 2'b10, 2'b10, 2);
    hold("bounce.final", 2'b11, 2'b10, SC + 1);
    step(1'b0, 2'b11);
    expect3("bounce.rise", 2'b11, 2'b01, 2'b00);
    step(1'b0, 2'b11);
    expect3("bounce.after", 2'b11, 2'b00, 2'b00);

    // Glitch on bit 1 one cycle shorter than the qualification window.
    repeat (8) step(1'b0, 2'b00);
    chk("glitch.pre", dout, 2'b00);
    hold("glitch.high", 2'b10, 2'b00, SC - 1);
    hold("glitch.low", 2'b00, 2'b00, 10);

    // Reset while bit 0 is mid-count discards the pending press.
    hold("rstmid.pre", 2'b01, 2'b00, 3);
    step(1'b1, 2'b01);
    expect3("rstmid.rst", 2'b00, 2'b00, 2'b00);
    hold("rstmid.requal", 2'b01, 2'b00, SC + 1);
    step(1'b0, 2'b01);
    expect3("rstmid.rise", 2'b01, 2'b01, 2'b00);
    step(1'b0, 2'b01);
    expect3("rstmid.after", 2'b01, 2'b00, 2'b00);

`ifdef DEBOUNCE_ACTIVE_LOW_EN
    // Raw pins: bit 0 low (pressed), bit 1 high (released).
    step_raw(1'b1, 2'b10);
    expect3("alow.rst", 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < SC + 1; k++) begin
      step_raw(1'b0, 2'b10);
      expect3("alow.wait", 2'b00, 2'b00, 2'b00);
    end
    step_raw(1'b0, 2'b10);
    expect3("alow.rise", 2'b01, 2'b01, 2'b00);
    step_raw(1'b0, 2'b10);
    expect3("alow.after", 2'b01, 2'b00, 2'b00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
